// File: rtl/ahb_pkg.sv
// Shared AHB types and helpers for the decode/response mux.
// Optional secure-region checking is enabled with AHB_SEC_CHECK_EN.
package ahb_pkg;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } trans_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } dflt_state_t;

  // NONSEQ and SEQ both carry bit 1; IDLE and BUSY never start a data phase.
  function automatic logic is_active(input logic [2:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational address decoder: region hits, lowest-index priority, optional
// secure-region blocking (AHB_SEC_CHECK_EN).
module ahb_addr_decoder
  import ahb_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumSubs   = 4,
  parameter logic [NumSubs*AddrWidth-1:0] SubBase    = '0,
  parameter logic [NumSubs*AddrWidth-1:0] SubMask    = '1,
  parameter logic [NumSubs-1:0]           SecureSubs = '0
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [2:0]           trans,
  input  logic                 nonSec,
  output logic [NumSubs-1:0]   sel,
  output logic                 hitNone
);

  logic [NumSubs-1:0] hit;
  logic [NumSubs-1:0] prio;

  generate
    for (genvar gi = 0; gi < NumSubs; gi++) begin : g_hit
      assign hit[gi] = (addr & SubMask[gi*AddrWidth +: AddrWidth]) ==
                       (SubBase[gi*AddrWidth +: AddrWidth] & SubMask[gi*AddrWidth +: AddrWidth]);
    end
  endgenerate

  always_comb begin
    logic found;
    prio  = '0;
    found = 1'b0;
    for (int i = 0; i < NumSubs; i++) begin
      if (hit[i] && !found) begin
        prio[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

`ifdef AHB_SEC_CHECK_EN
  // A non-secure active access to a secure region is diverted to the default slave.
  logic blocked;
  assign blocked = is_active(trans) && nonSec && |(prio & SecureSubs);
  assign sel     = blocked ? '0 : prio;
`else
  logic unused_sec;
  assign unused_sec = &{1'b0, trans, nonSec};
  assign sel        = prio;
`endif

  assign hitNone = (sel == '0);

endmodule

// File: rtl/ahb_decode_mux.sv
// Single-manager AHB decode and response mux with built-in default subordinate.
// Define AHB_SEC_CHECK_EN to reject non-secure accesses to secure regions.
module ahb_decode_mux
  import ahb_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumSubs   = 4,
  parameter logic [NumSubs*AddrWidth-1:0] SubBase    = '0,
  parameter logic [NumSubs*AddrWidth-1:0] SubMask    = '1,
  parameter logic [NumSubs-1:0]           SecureSubs = '0
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic [AddrWidth-1:0]         addr,
  input  logic [2:0]                   trans,
  input  logic                         nonSec,
  output logic [NumSubs-1:0]           sel,
  input  logic [NumSubs-1:0]           subReadyOut,
  input  logic [2*NumSubs-1:0]         subResp,
  input  logic [DataWidth*NumSubs-1:0] subRData,
  input  logic [NumSubs-1:0]           subExOkay,
  output logic                         ready,
  output logic [1:0]                   resp,
  output logic [DataWidth-1:0]         rData,
  output logic                         exOkay
);

  localparam int unsigned SelW = $clog2(NumSubs + 1);
  localparam logic [SelW-1:0] DfltSel = SelW'(NumSubs);

  logic            hit_none;
  logic [SelW-1:0] dsel_reg, dsel_next;
  logic            dactive_reg;
  logic            dflt_accept;
  dflt_state_t     state_reg, state_next;

  ahb_addr_decoder #(
    .AddrWidth (AddrWidth),
    .NumSubs   (NumSubs),
    .SubBase   (SubBase),
    .SubMask   (SubMask),
    .SecureSubs(SecureSubs)
  ) u_dec (
    .addr   (addr),
    .trans  (trans),
    .nonSec (nonSec),
    .sel    (sel),
    .hitNone(hit_none)
  );

  always_comb begin
    dsel_next = DfltSel;
    for (int i = NumSubs - 1; i >= 0; i--) begin
      if (sel[i]) dsel_next = SelW'(i);
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      dsel_reg    <= DfltSel;
      dactive_reg <= 1'b0;
      state_reg   <= ST_IDLE;
    end else begin
      state_reg <= state_next;
      if (ready) begin
        dsel_reg    <= dsel_next;
        dactive_reg <= is_active(trans);
      end
    end
  end

  always_comb begin
    ready  = 1'b1;
    resp   = OKAY;
    rData  = '0;
    exOkay = 1'b0;
    if (dsel_reg == DfltSel) begin
      case (state_reg)
        ST_ERR1: begin
          ready = 1'b0;
          resp  = ERROR;
        end
        ST_ERR2: resp = ERROR;
        default: ;
      endcase
    end else begin
      for (int i = 0; i < NumSubs; i++) begin
        if (dsel_reg == SelW'(i)) begin
          ready  = subReadyOut[i];
          resp   = subResp[2*i +: 2];
          rData  = subRData[DataWidth*i +: DataWidth];
          exOkay = subExOkay[i];
        end
      end
    end
  end

  assign dflt_accept = ready && is_active(trans) && hit_none;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (dflt_accept) state_next = ST_ERR1;
      ST_ERR1: state_next = ST_ERR2;
      ST_ERR2: state_next = dflt_accept ? ST_ERR1 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The FSM already encodes whether the default data phase is active.
  logic unused_ok;
  assign unused_ok = &{1'b0, dactive_reg};

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Directed self-checking bench for ahb_decode_mux (4 regions, 256 MB each).
module tb_ahb_decode_mux;
  import ahb_pkg::*;

  logic         clk = 1'b0;
  logic         nReset;
  logic [31:0]  addr;
  logic [2:0]   trans;
  logic         nonSec;
  logic [3:0]   sel;
  logic [3:0]   subReadyOut;
  logic [7:0]   subResp;
  logic [127:0] subRData;
  logic [3:0]   subExOkay;
  logic         ready;
  logic [1:0]   resp;
  logic [31:0]  rData;
  logic         exOkay;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ahb_decode_mux #(
    .DataWidth (32),
    .AddrWidth (32),
    .NumSubs   (4),
    .SubBase   ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SubMask   ({4{32'hF000_0000}}),
    .SecureSubs(4'b0010)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .addr       (addr),
    .trans      (trans),
    .nonSec     (nonSec),
    .sel        (sel),
    .subReadyOut(subReadyOut),
    .subResp    (subResp),
    .subRData   (subRData),
    .subExOkay  (subExOkay),
    .ready      (ready),
    .resp       (resp),
    .rData      (rData),
    .exOkay     (exOkay)
  );

  // Advance one edge and settle inputs just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0; addr = 32'h2000_0040; trans = {1'b0, IDLE}; nonSec = 1'b0;
    subReadyOut = 4'hF; subResp = '0; subExOkay = '0;
    subRData = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    #12;
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got=%0h exp=1", ready); else pass_cnt++;
    total_cnt++; if (resp !== 2'b00) $display("FAIL reset_resp got=%0h exp=0", resp); else pass_cnt++;
    total_cnt++; if (rData !== 32'h0) $display("FAIL reset_rdata got=%08h exp=0", rData); else pass_cnt++;
    total_cnt++; if (exOkay !== 1'b0) $display("FAIL reset_exokay got=%0h exp=0", exOkay); else pass_cnt++;
    total_cnt++; if (sel !== 4'b0100) $display("FAIL reset_sel got=%b exp=0100", sel); else pass_cnt++;
    step();
    nReset = 1'b1;
    step();
    total_cnt++; if (ready !== 1'b1) $display("FAIL release_ready got=%0h exp=1", ready); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_read();
    addr = 32'h2000_0040; trans = {1'b0, NONSEQ};
    #1;
    total_cnt++; if (sel !== 4'b0100) $display("FAIL read_sel got=%b exp=0100", sel); else pass_cnt++;
    step();
    trans = {1'b0, IDLE};
    subRData[64 +: 32] = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if (rData !== 32'hDEAD_BEEF) $display("FAIL read_rdata got=%08h exp=deadbeef", rData); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1) $display("FAIL read_ready got=%0h exp=1", ready); else pass_cnt++;
    $display("test_read addr=20000040 rdata=%08h", rData);
  endtask

  task automatic test_wait_states();
    addr = 32'h1000_0000; trans = {1'b0, NONSEQ};
    step();
    addr = 32'h3000_0004; subReadyOut[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++; if (ready !== 1'b0) $display("FAIL wait_ready[%0d] got=%0h exp=0", c, ready); else pass_cnt++;
      total_cnt++; if (rData !== 32'hA1A1_0001) $display("FAIL wait_hold[%0d] got=%08h exp=a1a10001", c, rData); else pass_cnt++;
      step();
    end
    subReadyOut[1] = 1'b1;
    #1;
    total_cnt++; if (ready !== 1'b1 || rData !== 32'hA1A1_0001)
      $display("FAIL wait_done got=%0h/%08h exp=1/a1a10001", ready, rData); else pass_cnt++;
    step();
    trans = {1'b0, IDLE}; subResp[6 +: 2] = ERROR; subExOkay[3] = 1'b1;
    #1;
    total_cnt++; if (rData !== 32'hA3A3_0003) $display("FAIL wait_switch got=%08h exp=a3a30003", rData); else pass_cnt++;
    total_cnt++; if (resp !== 2'b01) $display("FAIL sub_resp got=%0h exp=1", resp); else pass_cnt++;
    total_cnt++; if (exOkay !== 1'b1) $display("FAIL sub_exokay got=%0h exp=1", exOkay); else pass_cnt++;
    subResp[6 +: 2] = OKAY; subExOkay[3] = 1'b0;
    $display("test_wait_states sub1 3 waits then sub3");
  endtask

  task automatic test_default_err();
    addr = 32'h8000_0000; trans = {1'b0, NONSEQ};
    #1;
    total_cnt++; if (sel !== 4'b0000) $display("FAIL dflt_sel got=%b exp=0000", sel); else pass_cnt++;
    step();
    trans = {1'b0, IDLE};
    #1;
    total_cnt++; if (ready !== 1'b0 || resp !== 2'b01 || rData !== 32'h0)
      $display("FAIL dflt_err1 got=%0h/%0h/%08h exp=0/1/0", ready, resp, rData); else pass_cnt++;
    step();
    total_cnt++; if (ready !== 1'b1 || resp !== 2'b01)
      $display("FAIL dflt_err2 got=%0h/%0h exp=1/1", ready, resp); else pass_cnt++;
    step();
    total_cnt++; if (ready !== 1'b1 || resp !== 2'b00)
      $display("FAIL dflt_after got=%0h/%0h exp=1/0", ready, resp); else pass_cnt++;
    step();
    total_cnt++; if (ready !== 1'b1 || resp !== 2'b00)
      $display("FAIL dflt_idle got=%0h/%0h exp=1/0", ready, resp); else pass_cnt++;
    $display("test_default_err addr=80000000");
  endtask

  task automatic test_back_to_back();
    addr = 32'h8000_0000; trans = {1'b0, NONSEQ};
    step();
    total_cnt++; if (ready !== 1'b0) $display("FAIL b2b_err1a got=%0h exp=0", ready); else pass_cnt++;
    step();
    total_cnt++; if (ready !== 1'b1 || resp !== 2'b01)
      $display("FAIL b2b_err2a got=%0h/%0h exp=1/1", ready, resp); else pass_cnt++;
    step();
    addr = 32'h0000_0010;
    #1;
    total_cnt++; if (ready !== 1'b0 || resp !== 2'b01)
      $display("FAIL b2b_err1b got=%0h/%0h exp=0/1", ready, resp); else pass_cnt++;
    step();
    total_cnt++; if (ready !== 1'b1 || resp !== 2'b01)
      $display("FAIL b2b_err2b got=%0h/%0h exp=1/1", ready, resp); else pass_cnt++;
    step();
    addr = 32'h2000_0000;
    #1;
    total_cnt++; if (ready !== 1'b1 || rData !== 32'hA0A0_0000)
      $display("FAIL b2b_sub0 got=%0h/%08h exp=1/a0a00000", ready, rData); else pass_cnt++;
    step();
    trans = {1'b0, IDLE};
    #1;
    total_cnt++; if (rData !== 32'hDEAD_BEEF) $display("FAIL b2b_sub2 got=%08h exp=deadbeef", rData); else pass_cnt++;
    step();
    $display("test_back_to_back err-err-sub0-sub2");
  endtask

  task automatic test_reset_mid_err();
    addr = 32'h8000_0000; trans = {1'b0, NONSEQ};
    step();
    trans = {1'b0, IDLE};
    #1;
    total_cnt++; if (ready !== 1'b0) $display("FAIL rst_mid_pre got=%0h exp=0", ready); else pass_cnt++;
    nReset = 1'b0;
    #1;
    total_cnt++; if (ready !== 1'b1 || resp !== 2'b00)
      $display("FAIL rst_mid_async got=%0h/%0h exp=1/0", ready, resp); else pass_cnt++;
    step();
    nReset = 1'b1;
    step();
    total_cnt++; if (ready !== 1'b1 || resp !== 2'b00)
      $display("FAIL rst_mid_after got=%0h/%0h exp=1/0", ready, resp); else pass_cnt++;
    $display("test_reset_mid_err");
  endtask

  task automatic test_secure();
    addr = 32'h1000_0000; trans = {1'b0, NONSEQ}; nonSec = 1'b1;
    #1;
`ifdef AHB_SEC_CHECK_EN
    total_cnt++; if (sel !== 4'b0000) $display("FAIL sec_block_sel got=%b exp=0000", sel); else pass_cnt++;
    step();
    trans = {1'b0, IDLE};
    #1;
    total_cnt++; if (ready !== 1'b0 || resp !== 2'b01)
      $display("FAIL sec_err1 got=%0h/%0h exp=0/1", ready, resp); else pass_cnt++;
    step();
    total_cnt++; if (ready !== 1'b1 || resp !== 2'b01)
      $display("FAIL sec_err2 got=%0h/%0h exp=1/1", ready, resp); else pass_cnt++;
    step();
`else
    total_cnt++; if (sel !== 4'b0010) $display("FAIL nosec_sel got=%b exp=0010", sel); else pass_cnt++;
    step();
    trans = {1'b0, IDLE};
    #1;
    total_cnt++; if (ready !== 1'b1 || resp !== 2'b00 || rData !== 32'hA1A1_0001)
      $display("FAIL nosec_data got=%0h/%0h/%08h exp=1/0/a1a10001", ready, resp, rData); else pass_cnt++;
    step();
`endif
    trans = {1'b0, NONSEQ}; nonSec = 1'b0;
    #1;
    total_cnt++; if (sel !== 4'b0010) $display("FAIL sec_ok_sel got=%b exp=0010", sel); else pass_cnt++;
    step();
    trans = {1'b0, IDLE};
    #1;
    total_cnt++; if (ready !== 1'b1 || resp !== 2'b00 || rData !== 32'hA1A1_0001)
      $display("FAIL sec_ok_data got=%0h/%0h/%08h exp=1/0/a1a10001", ready, resp, rData); else pass_cnt++;
    $display("test_secure addr=10000000");
  endtask

  initial begin
    test_reset();
    test_read();
    test_wait_states();
    test_default_err();
    test_back_to_back();
    test_reset_mid_err();
    test_secure();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
